// File: rtl/fft_bfly_stage_pkg.sv
// Shared widths and defaults for the radix-2 butterfly stage that follows the twiddle multiplier.
// Optional clamp of the rescaled product is enabled by defining FFT_BFLY_SAT_EN.
package fft_bfly_stage_pkg;

  localparam int BFLY_IN_W   = 16;
  localparam int BFLY_PROD_W = 32;
  localparam int BFLY_FRAC   = 8;
  localparam int BFLY_OUT_W  = BFLY_IN_W + 2;
  localparam int BFLY_NPTS   = 4;

  // Frame counter width; a frame of N_PTS beats needs log2(N_PTS) bits.
  function automatic int bfly_cnt_w(input int n_pts);
    return (n_pts > 2) ? $clog2(n_pts) : 1;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Round-half-up rescale of a Q(2*FRAC) product to Q(FRAC), narrowed to IN_W+1 bits.
// With FFT_BFLY_SAT_EN the result is clamped and an overflow flag is produced; otherwise it wraps.
module fft_round_sat
  import fft_bfly_stage_pkg::*;
#(
  parameter int IN_W   = BFLY_IN_W,
  parameter int PROD_W = BFLY_PROD_W,
  parameter int FRAC   = BFLY_FRAC
) (
  input  logic [PROD_W-1:0] prod,
  output logic [IN_W:0]     q
`ifdef FFT_BFLY_SAT_EN
  ,
  output logic              sat
`endif
);

  localparam int SH_W = PROD_W + 1 - FRAC;
  localparam logic [PROD_W:0] RND = {{(PROD_W - FRAC + 1){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  logic [PROD_W:0] sum_s;
  logic [SH_W-1:0] sh_s;
  logic            unused_s;

  // One guard bit keeps the rounding add from overflowing; dropping the low bits is the arithmetic shift.
  assign sum_s = {prod[PROD_W-1], prod} + RND;
  assign sh_s  = sum_s[PROD_W:FRAC];

`ifdef FFT_BFLY_SAT_EN
  logic ovf_s;

  assign ovf_s    = ~((&sh_s[SH_W-1:IN_W]) | ~(|sh_s[SH_W-1:IN_W]));
  assign sat      = ovf_s;
  assign unused_s = ^sum_s[FRAC-1:0];

  // Clamp toward the sign of the unclamped value when the top bits disagree.
  always_comb begin
    q = sh_s[IN_W:0];
    if (ovf_s) begin
      q = {sh_s[SH_W-1], {IN_W{~sh_s[SH_W-1]}}};
    end else begin
      q = sh_s[IN_W:0];
    end
  end
`else
  assign q        = sh_s[IN_W:0];
  assign unused_s = ^{sum_s[FRAC-1:0], sh_s[SH_W-1:IN_W+1]};
`endif

endmodule

// File: rtl/fft_bfly_stage.sv
// Two-stage registered radix-2 butterfly: X0 = A + P', X1 = A - P' with valid/ready flow control
// and a frame-last tag every N_PTS output beats. Define FFT_BFLY_SAT_EN for clamping plus sat_flag.
module fft_bfly_stage
  import fft_bfly_stage_pkg::*;
#(
  parameter int IN_W   = BFLY_IN_W,
  parameter int PROD_W = BFLY_PROD_W,
  parameter int FRAC   = BFLY_FRAC,
  parameter int OUT_W  = IN_W + 2,
  parameter int N_PTS  = BFLY_NPTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a_r,
  input  logic [IN_W-1:0]   a_i,
  input  logic [PROD_W-1:0] p_r,
  input  logic [PROD_W-1:0] p_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  x0_r,
  output logic [OUT_W-1:0]  x0_i,
  output logic [OUT_W-1:0]  x1_r,
  output logic [OUT_W-1:0]  x1_i,
  output logic              out_last
`ifdef FFT_BFLY_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int CNT_W = bfly_cnt_w(N_PTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PTS - 1);

  logic              s1_adv_s, s2_adv_s;
  logic              s1_valid_r, s2_valid_r;
  logic [IN_W-1:0]   s1_ar_r, s1_ai_r;
  logic [IN_W:0]     s1_pr_r, s1_pi_r;
  logic [IN_W:0]     pr_s, pi_s;
  logic [OUT_W-1:0]  ar_ext_s, ai_ext_s, pr_ext_s, pi_ext_s;
  logic [OUT_W-1:0]  x0r_r, x0i_r, x1r_r, x1i_r;
  logic [CNT_W-1:0]  cnt_r;

`ifdef FFT_BFLY_SAT_EN
  logic sat_re_s, sat_im_s, sat_flag_r;

  fft_round_sat #(.IN_W(IN_W), .PROD_W(PROD_W), .FRAC(FRAC)) u_rs_re (.prod(p_r), .q(pr_s), .sat(sat_re_s));
  fft_round_sat #(.IN_W(IN_W), .PROD_W(PROD_W), .FRAC(FRAC)) u_rs_im (.prod(p_i), .q(pi_s), .sat(sat_im_s));
`else
  fft_round_sat #(.IN_W(IN_W), .PROD_W(PROD_W), .FRAC(FRAC)) u_rs_re (.prod(p_r), .q(pr_s));
  fft_round_sat #(.IN_W(IN_W), .PROD_W(PROD_W), .FRAC(FRAC)) u_rs_im (.prod(p_i), .q(pi_s));
`endif

  // Each stage moves whenever the stage after it can take its contents.
  assign s2_adv_s = ~s2_valid_r | out_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign in_ready = s1_adv_s;

  assign ar_ext_s = {{(OUT_W - IN_W){s1_ar_r[IN_W-1]}}, s1_ar_r};
  assign ai_ext_s = {{(OUT_W - IN_W){s1_ai_r[IN_W-1]}}, s1_ai_r};
  assign pr_ext_s = {{(OUT_W - IN_W - 1){s1_pr_r[IN_W]}}, s1_pr_r};
  assign pi_ext_s = {{(OUT_W - IN_W - 1){s1_pi_r[IN_W]}}, s1_pi_r};

  // Stage 1: capture the upper leg and the rescaled product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_ar_r    <= '0;
      s1_ai_r    <= '0;
      s1_pr_r    <= '0;
      s1_pi_r    <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_ar_r <= a_r;
        s1_ai_r <= a_i;
        s1_pr_r <= pr_s;
        s1_pi_r <= pi_s;
      end
    end
  end

  // Stage 2: butterfly sums at full output width, which cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      x0r_r      <= '0;
      x0i_r      <= '0;
      x1r_r      <= '0;
      x1i_r      <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        x0r_r <= ar_ext_s + pr_ext_s;
        x0i_r <= ai_ext_s + pi_ext_s;
        x1r_r <= ar_ext_s - pr_ext_s;
        x1i_r <= ai_ext_s - pi_ext_s;
      end
    end
  end

  // Frame position counts completed output transfers and wraps naturally at N_PTS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (s2_valid_r && out_ready) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_r;
  assign out_last  = s2_valid_r & (cnt_r == LAST_CNT);
  assign x0_r      = x0r_r;
  assign x0_i      = x0i_r;
  assign x1_r      = x1r_r;
  assign x1_i      = x1i_r;

`ifdef FFT_BFLY_SAT_EN
  // Sticky record of any clamp on an accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag_r <= 1'b0;
    end else if (in_valid && s1_adv_s && (sat_re_s || sat_im_s)) begin
      sat_flag_r <= 1'b1;
    end
  end

  assign sat_flag = sat_flag_r;
`endif

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Self-checking bench for fft_bfly_stage: directed cases plus randomized traffic against a
// plain-arithmetic model with a queue scoreboard. Honours FFT_BFLY_SAT_EN when defined.
module tb_fft_bfly_stage;

  localparam int IN_W = 16, PROD_W = 32, FRAC = 8, OUT_W = 18, N_PTS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0;
  logic              in_ready, out_valid, out_last;
  logic [IN_W-1:0]   a_r = '0, a_i = '0;
  logic [PROD_W-1:0] p_r = '0, p_i = '0;
  logic [OUT_W-1:0]  x0_r, x0_i, x1_r, x1_i;
`ifdef FFT_BFLY_SAT_EN
  logic              sat_flag;
`endif

  fft_bfly_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_r(a_r), .a_i(a_i), .p_r(p_r), .p_i(p_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i), .out_last(out_last)
`ifdef FFT_BFLY_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {longint x0r, x0i, x1r, x1i;} exp_t;

  int     n_cmp = 0, n_err = 0;
  exp_t   exp_q[$];
  bit     last_log[$];
  int     out_beats = 0, acc_cnt = 0;
  bit     model_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // P' = floor((P + 2^(FRAC-1)) / 2^FRAC), then clamped or wrapped into IN_W+1 bits.
  function automatic longint rescale(input logic [PROD_W-1:0] p, output bit sat);
    longint v, r, lim;
    lim = longint'(1) << IN_W;
    v = longint'($signed(p));
    r = (v + (longint'(1) << (FRAC - 1))) >>> FRAC;
    sat = 1'b0;
`ifdef FFT_BFLY_SAT_EN
    if (r > lim - 1) begin r = lim - 1; sat = 1'b1; end
    if (r < -lim) begin r = -lim; sat = 1'b1; end
`else
    r = r & ((lim << 1) - 1);
    if (r >= lim) r = r - (lim << 1);
`endif
    return r;
  endfunction

  function automatic exp_t model(input logic [IN_W-1:0] ar, ai, input logic [PROD_W-1:0] pr, pi,
                                 output bit sat);
    exp_t e;
    longint qr, qi, sa, sb;
    bit s1, s2;
    qr = rescale(pr, s1);
    qi = rescale(pi, s2);
    sa = longint'($signed(ar));
    sb = longint'($signed(ai));
    e.x0r = sa + qr; e.x1r = sa - qr;
    e.x0i = sb + qi; e.x1i = sb - qi;
    sat = s1 | s2;
    return e;
  endfunction

  // Scoreboard: every cycle with out_valid is compared against the oldest outstanding beat.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit s;
    if (!reset) begin
      exp_q.delete();
      out_beats = 0;
      model_sat = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = exp_q[0];
          check("x0_r", longint'($signed(x0_r)), e.x0r);
          check("x0_i", longint'($signed(x0_i)), e.x0i);
          check("x1_r", longint'($signed(x1_r)), e.x1r);
          check("x1_i", longint'($signed(x1_i)), e.x1i);
          check("out_last", longint'(out_last), longint'((out_beats % N_PTS) == N_PTS - 1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_beats++;
            last_log.push_back(out_last);
          end
        end
      end else begin
        check("out_last_idle", longint'(out_last), 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_r, a_i, p_r, p_i, s));
        if (s) model_sat = 1'b1;
        acc_cnt++;
      end
    end
  end

  task automatic send_beat(input logic [IN_W-1:0] ar, ai, input logic [PROD_W-1:0] pr, pi);
    bit acc;
    int waits;
    in_valid = 1'b1; a_r = ar; a_i = ai; p_r = pr; p_i = pi;
    waits = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 50);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waits;
    out_ready = 1'b1;
    waits = 0;
    while (exp_q.size() != 0 && waits < 50) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check("drain_left", longint'(exp_q.size()), 0);
  endtask

  task automatic single(input logic [IN_W-1:0] ar, input logic [PROD_W-1:0] pr,
                        input longint e0r, input longint e1r);
    int n;
    send_beat(ar, '0, pr, '0);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, 2);
    check("lit_x0_r", longint'($signed(x0_r)), e0r);
    check("lit_x1_r", longint'($signed(x1_r)), e1r);
    check("lit_x0_i", longint'($signed(x0_i)), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [PROD_W-1:0] rand_prod();
    logic [PROD_W-1:0] edges [6];
    edges = '{32'h7FFFFFFF, 32'h80000000, 32'h00FFFF7F, 32'h00FFFF80, 32'hFEFFFF80, 32'hFEFFFF7F};
    case ($urandom_range(0, 3))
      0: return PROD_W'($urandom);
      1: return edges[$urandom_range(0, 5)];
      default: return PROD_W'($signed(33'($urandom_range(0, 32'h00FFFFFF)) - 33'sh0800000));
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base, mask, v1, v2, v3;
    bit acc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_x0_r", longint'(x0_r), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Unity, rounding and saturation/wrap
    single(16'h0100, 32'h00010000, 512, 0);
    single(16'h0000, 32'h00000080, 1, -1);
    single(16'h0000, 32'hFFFFFF80, 0, 0);
`ifdef FFT_BFLY_SAT_EN
    single(16'h0000, 32'h7FFFFFFF, 65535, -65535);
    check("sat_flag", longint'(sat_flag), 1);
`else
    single(16'h0000, 32'h7FFFFFFF, 0, 0);
`endif

    // Backpressure: two beats absorbed, third refused, then all three out in order with no gaps
    out_ready = 1'b0; in_valid = 1'b1; a_r = 16'd1; a_i = '0; p_r = '0; p_i = '0;
    base = acc_cnt;
    @(posedge clk); #1 a_r = 16'd2;
    @(posedge clk); #1 a_r = 16'd3;
    @(negedge clk);
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_accepted", acc_cnt - base, 2);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); v1 = out_valid;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); v2 = out_valid;
    @(negedge clk); v3 = out_valid;
    check("bp_no_gaps", v1 + v2 + v3, 3);
    check("bp_total", acc_cnt - base, 3);
    drain();

    // Framing: eight back-to-back beats from a fresh frame
    do_reset();
    out_ready = 1'b1;
    last_log.delete();
    for (int i = 0; i < 8; i++) send_beat(IN_W'($urandom), IN_W'($urandom), rand_prod(), rand_prod());
    drain();
    mask = 0;
    foreach (last_log[i]) mask |= int'(last_log[i]) << i;
    check("frame_beats", last_log.size(), 8);
    check("frame_last_mask", mask, 32'h88);

    // Reset mid-frame with two beats in flight
    for (int i = 0; i < 2; i++) send_beat(IN_W'($urandom), '0, rand_prod(), '0);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send_beat(IN_W'($urandom), '0, rand_prod(), '0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_last", longint'(out_last), 0);
    check("midrst_x1_r", longint'(x1_r), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    last_log.delete();
    for (int i = 0; i < 4; i++) send_beat(IN_W'($urandom), IN_W'($urandom), rand_prod(), rand_prod());
    drain();
    mask = 0;
    foreach (last_log[i]) mask |= int'(last_log[i]) << i;
    check("midrst_last_mask", mask, 32'h8);

    // Randomized traffic with random backpressure
    acc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a_r = IN_W'($urandom); a_i = IN_W'($urandom);
        p_r = rand_prod(); p_i = rand_prod();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
`ifdef FFT_BFLY_SAT_EN
    check("sat_flag_final", longint'(sat_flag), longint'(model_sat));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
